sram_march_bist: RTL and testbench

//  March C- built-in self-test sequencer for one OpenRAM 1RW port (csb0/web0/wmask0/addr0/din0/dout0).

---
 rtl/sram_march_bist_pkg.sv | 35 +++
 rtl/sram_march_bist_checker.sv | 70 +++++++
 rtl/sram_march_bist.sv | 144 ++++++++++++++
 tb/tb_sram_march_bist.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_march_bist_pkg.sv
// sram_march_bist_pkg: FSM states, march element indices and the per-element op table
package sram_march_bist_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;
  // has_rd: element starts with a read; has_wr: element ends with a write;
  // rd_pol: background expected by the read (the write uses the opposite one);
  // down: address sweep N-1..0
  typedef struct packed {
    logic has_rd;
    logic has_wr;
    logic rd_pol;
    logic down;
  } elem_cfg_t;
  function automatic elem_cfg_t elem_cfg(input logic [2:0] e);
    case (e)
      E0:      elem_cfg = '{has_rd: 1'b0, has_wr: 1'b1, rd_pol: 1'b1, down: 1'b0};
      E1:      elem_cfg = '{has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b0, down: 1'b0};
      E2:      elem_cfg = '{has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b1, down: 1'b0};
      E3:      elem_cfg = '{has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b0, down: 1'b1};
      E4:      elem_cfg = '{has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b1, down: 1'b1};
      default: elem_cfg = '{has_rd: 1'b1, has_wr: 1'b0, rd_pol: 1'b0, down: 1'b0};
    endcase
  endfunction
  function automatic logic op_is_rd(input elem_cfg_t c, input logic op);
    op_is_rd = c.has_rd && !op;
  endfunction
  function automatic logic op_pol(input elem_cfg_t c, input logic op);
    op_pol = op_is_rd(c, op) ? c.rd_pol : !c.rd_pol;
  endfunction
endpackage

// File: rtl/sram_march_bist_checker.sv
// sram_march_bist_checker: read-latency pipe, comparator, first-fail capture, saturating error count
//   clk_i/rst_i  clock, sync active-high reset
//   clr_i        clear results (test start); flush_i drops in-flight reads (abort)
//   push_i       a read is on the port this cycle, with exp_i/addr_i/elem_i describing it
//   dout_i       macro read data; empty_o no reads in flight
//   fail_o/fail_addr_o/fail_elem_o/err_count_o  results
module sram_march_bist_checker #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            elem_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  empty_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [ERR_WIDTH-1:0]  err_count_o
);
  localparam int RL = READ_LATENCY;
  logic [RL-1:0] vld_q;
  logic [DATA_WIDTH-1:0] exp_q [RL];
  logic [ADDR_WIDTH-1:0] addr_q [RL];
  logic [2:0] elem_q [RL];
  logic miss;
  // The macro samples a read on the edge after it is driven, so the pipe is
  // loaded on that edge and its tail lines up with valid dout_i.
  assign miss = vld_q[RL-1] && !flush_i && (dout_i != exp_q[RL-1]);
  assign empty_o = ~|vld_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) vld_q <= '0;
    else begin
      vld_q[0] <= push_i;
      for (int i = 1; i < RL; i++) vld_q[i] <= vld_q[i-1];
    end
  end
  always_ff @(posedge clk_i) begin
    exp_q[0] <= exp_i;
    addr_q[0] <= addr_i;
    elem_q[0] <= elem_i;
    for (int i = 1; i < RL; i++) begin
      exp_q[i] <= exp_q[i-1];
      addr_q[i] <= addr_q[i-1];
      elem_q[i] <= elem_q[i-1];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      fail_o <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      err_count_o <= '0;
    end else if (miss) begin
      if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
      if (!fail_o) begin
        fail_o <= 1'b1;
        fail_addr_o <= addr_q[RL-1];
        fail_elem_o <= elem_q[RL-1];
      end
    end
  end
endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- self-test sequencer driving one OpenRAM 1RW port
//   wb_clk_i/wb_rst_i  clock, sync active-high reset
//   start_i/abort_i    start (IDLE/DONE only), abort (abort wins)
//   pattern_i          background 0, latched at start
//   csb0_o/web0_o/wmask0_o/addr0_o/din0_o/dout0_i  macro port
//   busy_o/done_o/fail_o/fail_addr_o/fail_elem_o/err_count_o  status and results
module sram_march_bist
  import sram_march_bist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int WMASK_WIDTH  = DATA_WIDTH/8,
  parameter int READ_LATENCY = 1,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [DATA_WIDTH-1:0]  pattern_i,
  output logic                   csb0_o,
  output logic                   web0_o,
  output logic [WMASK_WIDTH-1:0] wmask0_o,
  output logic [ADDR_WIDTH-1:0]  addr0_o,
  output logic [DATA_WIDTH-1:0]  din0_o,
  input  logic [DATA_WIDTH-1:0]  dout0_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [ADDR_WIDTH-1:0]  fail_addr_o,
  output logic [2:0]             fail_elem_o,
  output logic [ERR_WIDTH-1:0]   err_count_o
);
  state_e state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d, din_q, din_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic csb_q, csb_d, web_q, web_d, busy_q, busy_d, done_q, done_d;
  elem_cfg_t cfg, ncfg;
  logic active, start, abort, last_op, at_end, run_d, wr_d, pipe_empty, push;
  logic [DATA_WIDTH-1:0] exp_data;
  assign cfg = elem_cfg(elem_q);
  assign active = state_q == S_RUN || state_q == S_DRAIN;
  assign abort = active && abort_i;
  assign start = !active && start_i && !abort_i;
  assign last_op = !(cfg.has_rd && cfg.has_wr) || op_q;
  assign at_end = cfg.down ? addr_q == '0 : &addr_q;
  // Counters describe the op currently on the port; port registers are loaded
  // from the next-state counters so every output stays registered.
  always_comb begin
    state_d = state_q;
    elem_d = elem_q;
    op_d = op_q;
    addr_d = addr_q;
    pat_d = pat_q;
    if (abort) state_d = S_IDLE;
    else if (start) begin
      state_d = S_RUN;
      elem_d = E0;
      op_d = 1'b0;
      addr_d = '0;
      pat_d = pattern_i;
    end else if (state_q == S_RUN && !last_op) op_d = 1'b1;
    else if (state_q == S_RUN && !at_end) begin
      op_d = 1'b0;
      addr_d = cfg.down ? addr_q - 1'b1 : addr_q + 1'b1;
    end else if (state_q == S_RUN && elem_q == E5) begin
      op_d = 1'b0;
      state_d = S_DRAIN;
    end else if (state_q == S_RUN) begin
      op_d = 1'b0;
      elem_d = elem_q + 3'd1;
      addr_d = elem_cfg(elem_q + 3'd1).down ? '1 : '0;
    end else if (state_q == S_DRAIN && pipe_empty) state_d = S_DONE;
    ncfg = elem_cfg(elem_d);
    run_d = state_d == S_RUN;
    wr_d = run_d && !op_is_rd(ncfg, op_d);
    csb_d = !run_d;
    web_d = !wr_d;
    wmask_d = {WMASK_WIDTH{wr_d}};
    din_d = !wr_d ? '0 : op_pol(ncfg, op_d) ? ~pat_d : pat_d;
    busy_d = run_d || state_d == S_DRAIN;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      elem_q <= E0;
      op_q <= 1'b0;
      addr_q <= '0;
      pat_q <= '0;
      din_q <= '0;
      wmask_q <= '0;
      csb_q <= 1'b1;
      web_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q <= elem_d;
      op_q <= op_d;
      addr_q <= addr_d;
      pat_q <= pat_d;
      din_q <= din_d;
      wmask_q <= wmask_d;
      csb_q <= csb_d;
      web_q <= web_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign push = state_q == S_RUN && !csb_q && web_q;
  assign exp_data = op_pol(cfg, op_q) ? ~pat_q : pat_q;
  sram_march_bist_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .ERR_WIDTH(ERR_WIDTH)
  ) u_checker (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .clr_i(start),
    .flush_i(abort),
    .push_i(push),
    .exp_i(exp_data),
    .addr_i(addr_q),
    .elem_i(elem_q),
    .dout_i(dout0_i),
    .empty_o(pipe_empty),
    .fail_o(fail_o),
    .fail_addr_o(fail_addr_o),
    .fail_elem_o(fail_elem_o),
    .err_count_o(err_count_o)
  );
  assign csb0_o = csb_q;
  assign web0_o = web_q;
  assign wmask0_o = wmask_q;
  assign addr0_o = addr_q;
  assign din0_o = din_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: faulty-macro model plus march reference model checking sram_march_bist
module tb_sram_march_bist;
  localparam int N = 16;
  localparam int OPS = 10 * N;
  localparam int DONE_EDGE = OPS + 1 + 1;
  localparam int EL_N [6] = '{1, 2, 2, 2, 2, 1};
  localparam bit EL_DOWN [6] = '{0, 0, 0, 1, 1, 0};
  localparam bit EL_RD [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
  localparam bit EL_POL [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic [31:0] pattern_i = '0, din0_o, dout0_i = '0;
  logic csb0_o, web0_o, busy_o, done_o, fail_o;
  logic [3:0] wmask0_o, addr0_o, fail_addr_o;
  logic [2:0] fail_elem_o;
  logic [15:0] err_count_o;
  always #5 wb_clk_i = ~wb_clk_i;
  sram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .ERR_WIDTH(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
    .pattern_i(pattern_i), .csb0_o(csb0_o), .web0_o(web0_o), .wmask0_o(wmask0_o),
    .addr0_o(addr0_o), .din0_o(din0_o), .dout0_i(dout0_i), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o), .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o), .err_count_o(err_count_o)
  );
  bit st_en = 0, st_v = 0, cp_en = 0;
  int st_a = 0, st_b = 0, agg = 0, vic = 1;
  logic [31:0] mem [N];
  function automatic logic [31:0] rd_f(input logic [31:0] v, input int a);
    logic [31:0] r;
    r = v;
    if (st_en && a == st_a) r[st_b] = st_v;
    return r;
  endfunction
  always @(posedge wb_clk_i) begin
    if (!csb0_o && !web0_o) begin
      mem[addr0_o] <= din0_o;
      if (cp_en && int'(addr0_o) == agg && din0_o[0]) mem[vic][0] <= ~mem[vic][0];
    end else if (!csb0_o) dout0_i <= rd_f(mem[addr0_o], int'(addr0_o));
  end
  typedef struct packed {
    logic web;
    logic [3:0] wm;
    logic [3:0] a;
    logic [31:0] d;
  } op_t;
  op_t exp_q [$];
  bit m_fail;
  int m_faddr, m_felem, m_err;
  int n_vec = 0, n_err = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic build_model(input logic [31:0] pat);
    logic [31:0] rm [N];
    logic [31:0] d, v;
    int a;
    exp_q.delete();
    m_fail = 0; m_faddr = 0; m_felem = 0; m_err = 0;
    for (int i = 0; i < N; i++) rm[i] = $urandom;
    for (int e = 0; e < 6; e++)
      for (int j = 0; j < N; j++)
        for (int o = 0; o < EL_N[e]; o++) begin
          a = EL_DOWN[e] ? N - 1 - j : j;
          d = EL_POL[e][o] ? ~pat : pat;
          if (EL_RD[e][o]) begin
            exp_q.push_back({1'b1, 4'h0, 4'(a), 32'h0});
            v = rd_f(rm[a], a);
            if (v !== d) begin
              if (!m_fail) begin m_fail = 1; m_faddr = a; m_felem = e; end
              m_err++;
            end
          end else begin
            exp_q.push_back({1'b0, 4'hF, 4'(a), d});
            rm[a] = d;
            if (cp_en && a == agg && d[0]) rm[vic][0] = ~rm[vic][0];
          end
        end
  endtask
  task automatic start_run(input logic [31:0] pat);
    @(negedge wb_clk_i);
    pattern_i = pat;
    start_i = 1'b1;
    @(posedge wb_clk_i);
    #1 start_i = 1'b0;
  endtask
  task automatic run_to_done(input int pulse_at);
    int e, ops;
    op_t act;
    e = 0; ops = 0;
    while (!done_o && e < 400) begin
      if (!csb0_o) begin
        act = {web0_o, wmask0_o, addr0_o, web0_o ? 32'h0 : din0_o};
        ops++;
        if (exp_q.size() == 0) check("op_overflow", ops, OPS);
        else check($sformatf("op%0d", ops - 1), act, exp_q.pop_front());
      end
      start_i = (e == pulse_at);
      @(posedge wb_clk_i);
      #1 e++;
    end
    start_i = 1'b0;
    check("done_edge", e, DONE_EDGE);
    check("op_count", ops, OPS);
    check("busy_at_done", busy_o, 0);
  endtask
  task automatic check_res(input string n, input bit f, input int fa, input int fe, input int ec);
    check({n, "_fail"}, fail_o, f);
    check({n, "_faddr"}, fail_addr_o, fa);
    check({n, "_felem"}, fail_elem_o, fe);
    check({n, "_err"}, err_count_o, ec);
  endtask
  task automatic check_reset(input string n);
    check({n, "_port"}, {csb0_o, web0_o, wmask0_o, addr0_o, din0_o}, {2'b11, 40'h0});
    check({n, "_stat"}, {busy_o, done_o, fail_o, fail_addr_o, fail_elem_o, err_count_o}, 0);
  endtask
  typedef struct {
    logic [31:0] pat;
    bit st_en; int st_a, st_b; bit st_v;
    bit cp_en; int agg, vic;
    bit e_fail; int e_faddr, e_felem, e_err;
  } vec_t;
  vec_t tbl [5];
  initial begin
    tbl[0] = '{32'h0000_0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{32'h0000_0000, 1, 5, 3, 1, 0, 0, 1, 1, 5, 1, 3};
    tbl[2] = '{32'h5A5A_5A5A, 0, 0, 0, 0, 1, 7, 6, 1, 6, 2, 2};
    tbl[3] = '{32'hFFFF_0000, 1, 0, 31, 0, 0, 0, 1, 1, 0, 1, 3};
    tbl[4] = '{32'hFFFF_FFFF, 1, 15, 0, 1, 0, 0, 1, 1, 15, 2, 2};
    repeat (3) @(posedge wb_clk_i);
    #1 check_reset("reset");
    wb_rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st_en = tbl[i].st_en; st_a = tbl[i].st_a; st_b = tbl[i].st_b; st_v = tbl[i].st_v;
      cp_en = tbl[i].cp_en; agg = tbl[i].agg; vic = tbl[i].vic;
      build_model(tbl[i].pat);
      start_run(tbl[i].pat);
      run_to_done(-1);
      check_res($sformatf("tbl%0d", i), tbl[i].e_fail, tbl[i].e_faddr, tbl[i].e_felem, tbl[i].e_err);
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] pat;
      pat = $urandom;
      st_en = 1'($urandom_range(0, 1)); st_a = $urandom_range(0, N - 1);
      st_b = $urandom_range(0, 31); st_v = 1'($urandom_range(0, 1));
      cp_en = 1'($urandom_range(0, 1)); agg = $urandom_range(0, N - 1);
      vic = (agg + $urandom_range(1, N - 1)) % N;
      build_model(pat);
      start_run(pat);
      run_to_done(-1);
      check_res($sformatf("rnd%0d", i), m_fail, m_faddr, m_felem, m_err);
    end
    cp_en = 0; st_en = 1; st_a = 0; st_b = 3; st_v = 1;
    start_run(32'h0);
    repeat (39) @(posedge wb_clk_i);
    #1 abort_i = 1'b1;
    start_i = 1'b1;
    @(posedge wb_clk_i);
    #1 abort_i = 1'b0;
    start_i = 1'b0;
    check("abort_port", {csb0_o, web0_o}, 2'b11);
    check("abort_stat", {busy_o, done_o}, 2'b00);
    check("abort_hold", {fail_o, err_count_o}, {1'b1, 16'd1});
    @(posedge wb_clk_i);
    #1 check("abort_idle", busy_o, 0);
    st_en = 0;
    repeat (2) @(posedge wb_clk_i);
    build_model(32'h0);
    start_run(32'h0);
    run_to_done(-1);
    check_res("restart", 0, 0, 0, 0);
    start_run(32'hA5A5_0F0F);
    repeat (99) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    check_reset("midrst");
    build_model(32'h3C3C_C3C3);
    start_run(32'h3C3C_C3C3);
    run_to_done(50);
    check_res("busy_start", 0, 0, 0, 0);
    st_en = 1; st_a = 9; st_b = 17; st_v = 1;
    build_model(32'h0);
    start_run(32'h0);
    run_to_done(-1);
    check_res("pre_b2b", m_fail, m_faddr, m_felem, m_err);
    st_en = 0;
    build_model(32'h1234_5678);
    start_run(32'h1234_5678);
    check("b2b_clear", {done_o, busy_o, fail_o, err_count_o}, {1'b0, 1'b1, 1'b0, 16'd0});
    run_to_done(-1);
    check_res("b2b", 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
